// File: rtl/reset_sequencer.sv
// Staged reset release: waits for clock lock, holds, then frees each subsystem in order on ack.
// Define RESET_SEQ_TIMEOUT_EN to build the per-stage ack timeout and the FAULT state.
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready_in,
    input  logic [NUM_STAGES-1:0] stage_ack,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  sys_ready,
    output logic                  fault,
    output logic [3:0]            fault_stage
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HOLD     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [2:0] S_FAULT    = 3'd4;
`endif

    logic                  r_sync1;
    logic                  r_ready_s;
    logic [2:0]            r_state;
    logic [15:0]           r_hold_cnt;
    logic [3:0]            r_k;
    logic [NUM_STAGES-1:0] r_stage_reset;
    logic                  r_sys_ready;

    logic                  w_ack_k;
    logic                  w_last_stage;
    logic                  w_soft_restart;
    logic                  w_timeout;
    logic [3:0]            w_k_next;
    logic [NUM_STAGES-1:0] w_next_release;

    assign w_k_next       = r_k + 4'd1;
    assign w_last_stage   = (r_k == 4'(NUM_STAGES - 1));
    assign w_soft_restart = soft_reset_req && (r_state != S_IDLE);

    // Loop-based select keeps the 4-bit stage index legal for any NUM_STAGES.
    always_comb begin
        w_ack_k        = 1'b0;
        w_next_release = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_k == 4'(i)) begin
                w_ack_k = stage_ack[i];
            end
            if (w_k_next == 4'(i)) begin
                w_next_release[i] = 1'b1;
            end
        end
    end

    // Lock is asynchronous to clk; the synchroniser restarts from 0 on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_ready_s <= 1'b0;
        end else begin
            r_sync1   <= ready_in;
            r_ready_s <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !r_ready_s) begin
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
            r_k           <= '0;
            r_stage_reset <= '1;
            r_sys_ready   <= 1'b0;
        end else if (w_soft_restart) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_k           <= '0;
            r_stage_reset <= '1;
            r_sys_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_HOLD;
                    r_hold_cnt <= '0;
                end
                S_HOLD: begin
                    if (r_hold_cnt == 16'(HOLD_CYCLES - 1)) begin
                        r_state          <= S_WAIT_ACK;
                        r_k              <= '0;
                        r_stage_reset[0] <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_timeout) begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        r_state       <= S_FAULT;
                        r_stage_reset <= '1;
`endif
                    end else if (w_ack_k) begin
                        if (w_last_stage) begin
                            r_state     <= S_DONE;
                            r_sys_ready <= 1'b1;
                        end else begin
                            r_k           <= w_k_next;
                            r_stage_reset <= r_stage_reset & ~w_next_release;
                        end
                    end
                end
                S_DONE: begin
                end
`ifdef RESET_SEQ_TIMEOUT_EN
                S_FAULT: begin
                end
`endif
                default: begin
                    r_state       <= S_IDLE;
                    r_stage_reset <= '1;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_fault;
    logic [3:0]  r_fault_stage;

    // Timeout fires one edge after TIMEOUT_CYCLES ack-less cycles, so a late ack still wins.
    assign w_timeout = (r_state == S_WAIT_ACK) && (r_to_cnt == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else if (!r_ready_s) begin
            r_to_cnt <= '0;
        end else if (w_soft_restart) begin
            r_to_cnt      <= '0;
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else if (r_state == S_WAIT_ACK) begin
            if (w_timeout) begin
                r_to_cnt      <= '0;
                r_fault       <= 1'b1;
                r_fault_stage <= r_k;
            end else if (w_ack_k) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign fault       = r_fault;
    assign fault_stage = r_fault_stage;
`else
    localparam logic [15:0] LP_TIMEOUT_UNUSED = 16'(TIMEOUT_CYCLES);

    assign w_timeout   = 1'b0;
    assign fault       = 1'b0;
    assign fault_stage = 4'd0;
`endif

    assign stage_reset = r_stage_reset;
    assign sys_ready   = r_sys_ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios with literal timing, then random stimulus
// checked every cycle against a released-stage-count model. Adapts to RESET_SEQ_TIMEOUT_EN.
module tb_reset_sequencer;

   localparam int NS   = 4;
   localparam int HOLD = 16;
   localparam int TMO  = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          ready_in;
   logic [NS-1:0] stage_ack;
   logic          soft_reset_req;
   logic [NS-1:0] stage_reset;
   logic          sys_ready;
   logic          fault;
   logic [3:0]    fault_stage;

   reset_sequencer #(
      .NUM_STAGES    (NS),
      .HOLD_CYCLES   (HOLD),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ready_in      (ready_in),
      .stage_ack     (stage_ack),
      .soft_reset_req(soft_reset_req),
      .stage_reset   (stage_reset),
      .sys_ready     (sys_ready),
      .fault         (fault),
      .fault_stage   (fault_stage)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Edge counter: at a negedge it holds the number of the posedge just passed.
   int cyc = 0;
   always @(posedge clk) cyc++;

   int passCount  = 0;
   int totalCount = 0;

   // Single place where every comparison is counted and reported.
   task automatic checkOutput(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] required);
      totalCount++;
      if (actual === required) passCount++;
      else $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
   endtask

   // Reference model: tracks lock pipeline, hold progress and how many stages are out of reset.
   bit mSync0, mSync1, mActive, mStuck, mDone, mFault, modelValid;
   int mHold, mReleased, mWait, mFaultStage;

   task automatic modelStep();
      bit rs;
      int k;
      if (reset) begin
         {mSync0, mSync1, mActive, mStuck, mDone, mFault} = '0;
         mHold = 0; mReleased = 0; mWait = 0; mFaultStage = 0;
         modelValid = 1'b1;
         return;
      end
      rs = mSync1;
      mSync1 = mSync0;
      mSync0 = ready_in;
      if (!rs) begin
         mActive = 0; mStuck = 0; mDone = 0; mReleased = 0;
      end else if (soft_reset_req && mActive) begin
         mHold = 0; mReleased = 0; mDone = 0; mStuck = 0; mFault = 0;
      end else if (!mActive) begin
         mActive = 1; mHold = 0; mReleased = 0;
      end else if (!(mStuck || mDone)) begin
         if (mReleased == 0) begin
            if (mHold == HOLD - 1) begin mReleased = 1; mWait = 0; end
            else mHold++;
         end else begin
            k = mReleased - 1;
`ifdef RESET_SEQ_TIMEOUT_EN
            if (mWait == TMO) begin
               mStuck = 1; mFault = 1; mFaultStage = k;
            end else
`endif
            if (stage_ack[k]) begin
               if (mReleased == NS) mDone = 1;
               else begin mReleased++; mWait = 0; end
            end else begin
               mWait++;
            end
         end
      end
   endtask

   always @(posedge clk) modelStep();

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [NS-1:0] expRst;
      if (modelValid) begin
         for (int i = 0; i < NS; i++) expRst[i] = !(mActive && !mStuck && i < mReleased);
         checkOutput("cyc_stage_reset", 32'(stage_reset), 32'(expRst));
         checkOutput("cyc_sys_ready", 32'(sys_ready), 32'(mDone));
         checkOutput("cyc_fault", 32'(fault), 32'(mFault));
`ifdef RESET_SEQ_TIMEOUT_EN
         if (mFault) checkOutput("cyc_fault_stage", 32'(fault_stage), mFaultStage);
`else
         checkOutput("cyc_fault_stage", 32'(fault_stage), 0);
`endif
      end
   end

   // Ack responder: stage i acks ackDelay[i]+1 cycles after release; -1 withholds the ack.
   int relCnt[NS];
   int ackDelay[NS];
   bit ackNoise = 1'b0;
   always @(negedge clk) begin
      for (int i = 0; i < NS; i++) begin
         if (stage_reset[i] !== 1'b0) begin
            relCnt[i] = 0;
            stage_ack[i] = ackNoise ? 1'($urandom_range(0, 1)) : 1'b0;
         end else begin
            relCnt[i]++;
            stage_ack[i] = (ackDelay[i] >= 0) && (relCnt[i] >= ackDelay[i] + 1);
         end
      end
   end

   function automatic logic pick(input int sel);
      case (sel)
         0: return stage_reset[0];
         1: return stage_reset[1];
         2: return stage_reset[2];
         3: return stage_reset[3];
         4: return sys_ready;
         default: return fault;
      endcase
   endfunction

   // Bounded wait; atCyc is -1 when the level never appeared.
   task automatic waitFor(input int sel, input logic val, input int limit, output int atCyc);
      atCyc = -1;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (pick(sel) === val) begin
            atCyc = cyc;
            break;
         end
      end
   endtask

   task automatic pulseSoft();
      soft_reset_req = 1'b1;
      @(negedge clk);
      soft_reset_req = 1'b0;
   endtask

   task automatic setDelays(input int d);
      for (int i = 0; i < NS; i++) ackDelay[i] = d;
   endtask

   // Random lock drops, soft requests, resets, ack latencies and ack noise.
   task automatic applyStimulus(input int cycles);
      int s, p;
      ackNoise = 1'b1;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 599) == 0);
         soft_reset_req = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 249) == 0) ready_in = !ready_in;
         if ($urandom_range(0, 39) == 0) begin
            s = $urandom_range(0, NS - 1);
            p = $urandom_range(0, 9);
            if (p < 6) ackDelay[s] = $urandom_range(0, 8);
            else if (p < 9) ackDelay[s] = $urandom_range(TMO - 4, TMO + 4);
            else ackDelay[s] = -1;
         end
      end
      reset = 1'b0;
      soft_reset_req = 1'b0;
      ackNoise = 1'b0;
   endtask

   int t, at, atF;

   initial begin
      reset = 1'b1; ready_in = 1'b0; soft_reset_req = 1'b0;
      setDelays(5);
      repeat (3) @(negedge clk);
      checkOutput("rst_stage_reset", 32'(stage_reset), 32'hF);
      checkOutput("rst_sys_ready", 32'(sys_ready), 0);
      checkOutput("rst_fault", 32'(fault), 0);
      checkOutput("rst_fault_stage", 32'(fault_stage), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Nominal: lock at t, 3 edges to HOLD, 16 hold cycles, 6-cycle spacing per stage.
      t = cyc; ready_in = 1'b1;
      waitFor(0, 1'b0, 100, at); checkOutput("nom_rst0_fall", at - t, 19);
      waitFor(1, 1'b0, 100, at); checkOutput("nom_rst1_fall", at - t, 25);
      waitFor(2, 1'b0, 100, at); checkOutput("nom_rst2_fall", at - t, 31);
      waitFor(3, 1'b0, 100, at); checkOutput("nom_rst3_fall", at - t, 37);
      waitFor(4, 1'b1, 100, at); checkOutput("nom_sys_ready", at - t, 43);

      // Lock loss in DONE, then full rerun.
      repeat (4) @(negedge clk);
      t = cyc; ready_in = 1'b0;
      waitFor(4, 1'b0, 10, at); checkOutput("lock_drop_latency", at - t, 3);
      checkOutput("lock_drop_rst", 32'(stage_reset), 32'hF);
      repeat (5) @(negedge clk);
      t = cyc; ready_in = 1'b1;
      waitFor(4, 1'b1, 100, at); checkOutput("lock_rerun_ready", at - t, 43);

      // Stage 2 ack withheld after a soft restart from DONE.
      ackDelay[2] = -1;
      repeat (2) @(negedge clk);
      t = cyc; pulseSoft();
      waitFor(2, 1'b0, 100, at); checkOutput("soft_rst2_fall", at - t, 29);
`ifdef RESET_SEQ_TIMEOUT_EN
      waitFor(5, 1'b1, 200, atF); checkOutput("tmo_latency", atF - at, TMO + 1);
      checkOutput("tmo_fault_stage", 32'(fault_stage), 2);
      checkOutput("tmo_stage_reset", 32'(stage_reset), 32'hF);
      repeat (20) @(negedge clk);
      checkOutput("tmo_held", 32'(fault), 1);
`else
      repeat (5000) @(negedge clk);
      checkOutput("nomacro_fault", 32'(fault), 0);
      checkOutput("nomacro_waiting", 32'(stage_reset), 32'h8);
      ackDelay[2] = 5;
      waitFor(4, 1'b1, 100, at); checkOutput("nomacro_resume", 32'(at >= 0), 1);
`endif

      // Soft request in FAULT (or DONE without the timeout) restarts the whole sequence.
      setDelays(5);
      t = cyc; pulseSoft();
      checkOutput("soft_fault_clear", 32'(fault), 0);
      checkOutput("soft_stage_reset", 32'(stage_reset), 32'hF);
      waitFor(4, 1'b1, 100, at); checkOutput("soft_sys_ready", at - t, 41);

`ifdef RESET_SEQ_TIMEOUT_EN
      // Ack on the last counted cycle beats the timeout.
      ackDelay[2] = TMO - 1;
      t = cyc; pulseSoft();
      waitFor(4, 1'b1, 300, at); checkOutput("edge_ack_ready", at - t, 29 + TMO + 6);
      checkOutput("edge_ack_fault", 32'(fault), 0);
      ackDelay[2] = 5;
`endif

      // Reset while waiting on stage 1, with a simultaneous soft request.
      pulseSoft();
      waitFor(1, 1'b0, 100, at);
      reset = 1'b1; soft_reset_req = 1'b1;
      @(negedge clk);
      checkOutput("midrst_stage_reset", 32'(stage_reset), 32'hF);
      checkOutput("midrst_sys_ready", 32'(sys_ready), 0);
      checkOutput("midrst_fault", 32'(fault), 0);
      checkOutput("midrst_fault_stage", 32'(fault_stage), 0);
      t = cyc; reset = 1'b0; soft_reset_req = 1'b0;
      waitFor(4, 1'b1, 100, at); checkOutput("midrst_rerun_ready", at - t, 43);

      applyStimulus(4000);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Downstream consumer of the `system_control` clock/reset pair. It waits for the clock manager to report lock, then releases per-subsystem resets one stage at a time. Each stage must acknowledge before the next is released. Once all stages acknowledge, it asserts a single system-ready flag. It sits between clock/reset generation and the processor, memory and peripheral subsystems, and re-sequences on lock loss or on a software reset request.

## Interface
- `NUM_STAGES`, 4: number of sequenced reset domains, 1..16.
- `HOLD_CYCLES`, 16: cycles all stages stay in reset after lock is seen, 1..65535.
- `TIMEOUT_CYCLES`, 1024: maximum cycles to wait for one stage ack, 2..65535.

Ports:
- `clk` in 1: system clock (BUFG output of clock manager).
- `reset` in 1: already decided — one clock; reset is synchronous and active-high.
- `ready_in` in 1: clock-manager lock (`XREADY`), treated as asynchronous.
- `stage_ack` in NUM_STAGES: per-stage "out of reset, initialised" level.
- `soft_reset_req` in 1: single-cycle request to re-run the sequence.
- `stage_reset` out NUM_STAGES: per-stage active-high reset, registered.
- `sys_ready` out 1: high only when every stage has acknowledged.
- `fault` out 1: ack timeout occurred.
- `fault_stage` out 4: index of the stage that timed out.

## Operation
- `ready_in` passes through a 2-flop synchroniser; `ready_s` is the synchronised value. All decisions use `ready_s`.
- States: IDLE, HOLD, WAIT_ACK, DONE, FAULT. A stage index `k` (4 bits) tracks the stage being waited on.
- IDLE: all `stage_reset`=1. If `ready_s`=1, go to HOLD with hold counter = 0.
- HOLD: the counter increments each cycle. When counter == HOLD_CYCLES-1, go to WAIT_ACK with k=0 and clear `stage_reset[0]`.
- WAIT_ACK: the timeout counter increments each cycle. When `stage_ack[k]`=1:
  - If k == NUM_STAGES-1, go to DONE.
  - Otherwise set k=k+1, clear `stage_reset[k+1]`, and zero the timeout counter.
- DONE: `sys_ready`=1. `stage_ack` is ignored.
- FAULT (built only with the macro): all `stage_reset`=1, `fault`=1, `fault_stage`=k. This state is held until `reset` or `soft_reset_req`.
- Priority, highest first: `reset`; `ready_s`=0, which forces IDLE from any state with all `stage_reset`=1, clears `sys_ready` and leaves `fault` unchanged; `soft_reset_req`; normal transitions.
- `soft_reset_req` in HOLD, WAIT_ACK, DONE or FAULT: set all `stage_reset`=1, `sys_ready`=0, `fault`=0, and restart HOLD with counter 0. In IDLE it is ignored.
- Stages are released strictly in ascending index order. A released stage stays released until a re-sequence.
- If `stage_ack[k]` is already high on entry to WAIT_ACK, it is sampled on the next cycle, so each stage takes at least 1 cycle.

## Timing
- Reset values: `stage_reset`=all 1, `sys_ready`=0, `fault`=0, `fault_stage`=0. State is IDLE and both counters are 0.
- `ready_in` rising edge to HOLD entry: 3 clk edges (2 sync + 1 FSM).
- HOLD entry to `stage_reset[0]` falling: exactly HOLD_CYCLES cycles.
- `stage_ack[k]` sampled high to `stage_reset[k+1]` falling: 1 cycle.
- Last ack sampled high to `sys_ready` rising: 1 cycle.
- Timeout: if ack is not seen in the TIMEOUT_CYCLES cycles after stage k's release, FAULT is entered on the next edge. An ack sampled on the final counted cycle wins over the timeout.
- `ready_s` falling to `stage_reset` all 1 and `sys_ready`=0: 1 cycle.
- All outputs are registered with no combinational input-to-output paths.

## Configuration
- `RESET_SEQ_TIMEOUT_EN` defined: the timeout counter and FAULT state are built, and `fault` and `fault_stage` operate as described.
- Not defined: WAIT_ACK waits indefinitely, no timeout counter is built, and `fault`=0 and `fault_stage`=0 permanently.

## Test plan
Bench settings: NUM_STAGES=4, HOLD_CYCLES=16, TIMEOUT_CYCLES=64, macro defined unless noted.
- **Nominal sequence.** Stimulus: `ready_in` rises at cycle 10, each ack returns 5 cycles after its reset falls. Response: `stage_reset[0]` falls at cycle 29, `stage_reset[1..3]` follow at 6-cycle spacing, `sys_ready`=1 one cycle after `stage_ack[3]`.
- **Timeout.** Stimulus: `stage_ack[2]` held 0. Response: `fault`=1 and `fault_stage`=2 exactly 65 cycles after `stage_reset[2]` falls, with `stage_reset`=4'hF.
- **Lock loss.** Stimulus: `ready_in` drops while in DONE. Response: `stage_reset`=4'hF and `sys_ready`=0 within 3 cycles. When `ready_in` returns, the full sequence reruns.
- **Soft reset.** Stimulus: `soft_reset_req` pulse in FAULT. Response: `fault` clears, HOLD restarts, and the sequence completes when acks are supplied.
- **Reset mid-sequence.** Stimulus: `reset` asserted in WAIT_ACK with k=1. Response: next cycle all outputs are at reset values, even if `soft_reset_req` is high.
- **Macro undefined.** Stimulus: ack withheld for 5000 cycles. Response: `fault` stays 0, remains in WAIT_ACK, and the sequence resumes when the ack arrives.
